bsg_manycore_crossbar_out_arbiter: RTL and testbench

- Sequences one output column of the manycore crossbar.
- Arbitrates among num_in_p crossbar-format requesters, each carrying a flattened destination index in its low bits.
- Only requests addressed to this column (out_id_p) are considered. A winner is picked round-robin.
- Winning packets are forwarded through a registered output stage under credit-based flow control, toward a link adapter that returns credit pulses.

---
 rtl/bsg_manycore_crossbar_out_arbiter.sv | 134 +++++++++++++
 tb/tb_bsg_manycore_crossbar_out_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_crossbar_out_arbiter.sv
// Output-column arbiter for the manycore crossbar: round-robin grant among requesters
// addressed to this column, registered output stage, credit-based flow control.
module bsg_manycore_crossbar_out_arbiter #(
  parameter int num_in_p      = 4,
  parameter int data_width_p  = 32,
  parameter int out_id_p      = 0,
  parameter int max_credits_p = 4,
  localparam int lg_num_in_lp  = (num_in_p > 1) ? $clog2(num_in_p) : 1,
  localparam int lg_credits_lp = $clog2(max_credits_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_in_p-1:0]              v_i,
  input  logic [num_in_p*data_width_p-1:0] data_i,
  output logic [num_in_p-1:0]              yumi_o,
  output logic                             v_o,
  output logic [data_width_p-1:0]          data_o,
  input  logic                             credit_i,
  output logic [lg_credits_lp-1:0]         credits_o,
  output logic [31:0]                      stall_cnt_o
);

  localparam logic [lg_num_in_lp-1:0]  out_id_lp      = lg_num_in_lp'(out_id_p);
  localparam logic [lg_num_in_lp-1:0]  last_idx_lp    = lg_num_in_lp'(num_in_p - 1);
  localparam logic [lg_credits_lp-1:0] max_credits_lp = lg_credits_lp'(max_credits_p);

  logic [num_in_p-1:0]      req;
  logic                     any_req;
  logic                     found;
  logic                     grant;
  logic [lg_num_in_lp-1:0]  winner;
  logic [data_width_p-1:0]  win_data;

  logic [lg_num_in_lp-1:0]  ptr_q, ptr_d;
  logic [lg_credits_lp-1:0] credits_q, credits_d;
  logic [31:0]              stall_q, stall_d;
  logic                     v_q, v_d;
  logic [data_width_p-1:0]  data_q, data_d;

  // Only the low destination bits are decoded; the rest of the packet is opaque.
  always_comb begin
    for (int k = 0; k < num_in_p; k++) begin
      req[k] = v_i[k] & (data_i[k*data_width_p +: lg_num_in_lp] == out_id_lp);
    end
  end

  assign any_req = |req;

  // Two passes implement the wrap-around search: first at/above the pointer, then from 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < num_in_p; k++) begin
      if (!found && req[k] && (lg_num_in_lp'(k) >= ptr_q)) begin
        found  = 1'b1;
        winner = lg_num_in_lp'(k);
      end
    end
    for (int k = 0; k < num_in_p; k++) begin
      if (!found && req[k]) begin
        found  = 1'b1;
        winner = lg_num_in_lp'(k);
      end
    end
  end

  assign grant = found & (credits_q != '0) & ~reset_i;

  always_comb begin
    yumi_o = '0;
    if (grant) yumi_o[winner] = 1'b1;
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < num_in_p; k++) begin
      if (lg_num_in_lp'(k) == winner) win_data = data_i[k*data_width_p +: data_width_p];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (winner == last_idx_lp) ? '0 : winner + lg_num_in_lp'(1);
  end

  // A credit arriving at max is a downstream bug; saturate rather than wrap.
  always_comb begin
    credits_d = credits_q;
    case ({grant, credit_i})
      2'b10:   credits_d = credits_q - lg_credits_lp'(1);
      2'b01:   if (credits_q != max_credits_lp) credits_d = credits_q + lg_credits_lp'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (any_req && (credits_q == '0) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_comb begin
    v_d    = grant;
    data_d = grant ? win_data : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q     <= '0;
      credits_q <= max_credits_lp;
      stall_q   <= '0;
      v_q       <= 1'b0;
      data_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      stall_q   <= stall_d;
      v_q       <= v_d;
      data_q    <= data_d;
    end
  end

  assign v_o         = v_q;
  assign data_o      = data_q;
  assign credits_o   = credits_q;
  assign stall_cnt_o = stall_q;

  credit_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
      !(credit_i && (credits_q == max_credits_lp)))
    else $error("credit_i returned while credit counter already at max_credits_p");

  yumi_onehot_a: assert property (@(posedge clk_i) $onehot0(yumi_o))
    else $error("yumi_o has more than one bit set");

endmodule

// File: tb/tb_bsg_manycore_crossbar_out_arbiter.sv
// Bench for bsg_manycore_crossbar_out_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_bsg_manycore_crossbar_out_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int OUT = 2;
  localparam int MAX = 4;
  localparam int LGC = 3;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   yumi_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           credit_i;
  logic [LGC-1:0] credits_o;
  logic [31:0]    stall_cnt_o;

  always #5 clk = ~clk;

  bsg_manycore_crossbar_out_arbiter #(
    .num_in_p(N), .data_width_p(W), .out_id_p(OUT), .max_credits_p(MAX)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
    .v_o(v_o), .data_o(data_o), .credit_i(credit_i), .credits_o(credits_o),
    .stall_cnt_o(stall_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus state
  logic [N-1:0] vin;
  logic [W-1:0] din [N];
  int           cmode = 1;
  logic         prev_mv = 1'b0;

  // Model state
  int           m_valid = 0;
  int           m_ptr;
  int           m_cr;
  logic [31:0]  m_stall;
  logic         m_v;
  logic [W-1:0] m_data;
  logic [N-1:0] m_last_yumi = '0;

  task automatic apply();
    v_i = vin;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = din[k];
  endtask

  // cmode 0: no credits, 1: return v_o one cycle late, 2: random returns
  task automatic step();
    @(posedge clk);
    #1;
    case (cmode)
      1:       credit_i = prev_mv && (m_cr < MAX);
      2:       credit_i = ($urandom_range(0, 2) == 0) && (m_cr < MAX);
      default: credit_i = 1'b0;
    endcase
    prev_mv = m_v;
  endtask

  function automatic logic [W-1:0] fdat(input int k);
    return 32'hC0DE_0002 | (k << 8);
  endfunction

  // Behavioural model and per-cycle comparison
  always @(negedge clk) begin
    int win;
    int k;
    int old_cr;
    logic [N-1:0] exp_y;
    if (m_valid != 0) begin
      chk("v_o", 64'(v_o), 64'(m_v));
      chk("data_o", 64'(data_o), 64'(m_data));
      chk("credits_o", 64'(credits_o), 64'(m_cr));
      chk("stall_cnt_o", 64'(stall_cnt_o), 64'(m_stall));
    end
    if (reset_i) begin
      if (m_valid != 0) chk("yumi_in_reset", 64'(yumi_o), 64'd0);
      m_ptr = 0; m_cr = MAX; m_stall = '0; m_v = 1'b0; m_data = '0;
      m_last_yumi = '0;
      m_valid = 1;
    end else if (m_valid != 0) begin
      win = -1;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (win < 0 && v_i[k] && (data_i[k*W +: 2] == OUT)) win = k;
      end
      exp_y = '0;
      if (win >= 0 && m_cr > 0) exp_y[win] = 1'b1;
      chk("yumi_o", 64'(yumi_o), 64'(exp_y));
      old_cr = m_cr;
      if (exp_y != '0) begin
        m_v    = 1'b1;
        m_data = data_i[win*W +: W];
        m_ptr  = (win + 1) % N;
        m_cr   = m_cr - 1;
      end else begin
        m_v = 1'b0;
      end
      if (credit_i) m_cr = m_cr + 1;
      if (m_cr > MAX) m_cr = MAX;
      if (win >= 0 && old_cr == 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      m_last_yumi = exp_y;
    end
  end

  logic [3:0] fair_y [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
  int         fair_d [6] = '{0, 0, 1, 2, 3, 0};
  logic [3:0] ex_y  [17] = '{2, 2, 2, 2, 0, 0, 0, 0, 2, 0, 0, 2, 2, 0, 0, 2, 0};
  int         ex_cr [17] = '{4, 3, 2, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};
  int         ex_st [17] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 4, 5, 6, 6, 6, 7, 8, 8};

  initial begin
    reset_i = 1'b1;
    credit_i = 1'b0;
    vin = '0;
    for (int k = 0; k < N; k++) din[k] = '0;
    apply();
    step();
    step();
    reset_i = 1'b0;

    // Round-robin fairness with credits returned one cycle after v_o
    for (int c = 0; c < 6; c++) begin
      step();
      for (int k = 0; k < N; k++) din[k] = fdat(k);
      vin = (c < 5) ? 4'b1111 : 4'b0000;
      apply();
      @(negedge clk);
      chk("fair_yumi", 64'(yumi_o), 64'(fair_y[c]));
      if (c >= 1) begin
        chk("fair_v_o", 64'(v_o), 64'd1);
        chk("fair_data_o", 64'(data_o), 64'(fdat(fair_d[c])));
      end
    end

    // Destination filter: input 0 targets column 1, input 3 targets this column
    step();
    vin = 4'b1001; din[0] = 32'h1111_0001; din[3] = 32'h3333_0002; apply();
    @(negedge clk);
    chk("filter_yumi", 64'(yumi_o), 64'b1000);
    for (int c = 0; c < 3; c++) begin
      step();
      vin = 4'b0001; apply();
      @(negedge clk);
      chk("filter_no_grant", 64'(yumi_o), 64'd0);
    end

    // Wrap-around: move pointer to 3, then inputs 0 and 2 compete
    step();
    vin = 4'b0100; din[2] = 32'h2222_0002; apply();
    @(negedge clk);
    chk("wrap_setup", 64'(yumi_o), 64'b0100);
    step();
    vin = 4'b0101; din[0] = 32'h0A0A_0002; din[2] = 32'h2B2B_0002; apply();
    @(negedge clk);
    chk("wrap_first", 64'(yumi_o), 64'b0001);
    step();
    vin = 4'b0100; apply();
    @(negedge clk);
    chk("wrap_second", 64'(yumi_o), 64'b0100);
    step();
    vin = 4'b0000; apply();
    @(negedge clk);
    chk("wrap_data_o", 64'(data_o), 64'h2B2B_0002);
    for (int c = 0; c < 4; c++) step();

    // Credit exhaustion, single-credit regrant, simultaneous grant+credit, reset mid-stream
    cmode = 0;
    din[1] = 32'h5555_0002;
    for (int c = 0; c < 17; c++) begin
      step();
      if (c == 7 || c == 10 || c == 11 || c == 14 || c == 15) credit_i = 1'b1;
      reset_i = (c == 16);
      vin = 4'b0010; apply();
      @(negedge clk);
      chk("exh_yumi", 64'(yumi_o), 64'(ex_y[c]));
      chk("exh_credits", 64'(credits_o), 64'(ex_cr[c]));
      chk("exh_stall", 64'(stall_cnt_o), 64'(ex_st[c]));
      if (c == 16) chk("pre_reset_v_o", 64'(v_o), 64'd1);
    end
    step();
    reset_i = 1'b0;
    din[0] = 32'h7000_0002; din[2] = 32'h7200_0002; din[3] = 32'h7300_0002;
    vin = 4'b1111; apply();
    @(negedge clk);
    chk("post_reset_v_o", 64'(v_o), 64'd0);
    chk("post_reset_credits", 64'(credits_o), 64'(MAX));
    chk("post_reset_stall", 64'(stall_cnt_o), 64'd0);
    chk("post_reset_ptr_grant", 64'(yumi_o), 64'b0001);

    // Randomized traffic obeying the requester hold-until-yumi contract
    cmode = 2;
    for (int c = 0; c < 3000; c++) begin
      step();
      reset_i = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if (!vin[k] || m_last_yumi[k]) begin
          vin[k] = 1'($urandom_range(0, 1));
          din[k] = $urandom;
          din[k][1:0] = ($urandom_range(0, 1) == 0) ? 2'(OUT) : 2'($urandom_range(0, 3));
        end
      end
      apply();
    end
    step();
    reset_i = 1'b0;
    vin = '0; apply();
    for (int c = 0; c < 4; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
